// File: rtl/rr_stream_arbiter.sv
// Round-robin packet arbiter: merges P_NUM_INPUTS valid/ready/last streams onto one output.
// Optional macro RR_STREAM_ARBITER_FAST_PATH_EN gives input 0 a zero-latency path from IDLE.
module rr_stream_arbiter #(
    parameter int unsigned P_NUM_INPUTS = 4,
    parameter int unsigned P_DATA_WIDTH = 32
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [P_NUM_INPUTS-1:0]              valid_in,
    input  logic [P_NUM_INPUTS-1:0]              last_in,
    input  logic [P_NUM_INPUTS*P_DATA_WIDTH-1:0] data_in,
    output logic [P_NUM_INPUTS-1:0]              ready_in,
    output logic                                 valid_out,
    output logic                                 last_out,
    output logic [P_DATA_WIDTH-1:0]              data_out,
    input  logic                                 ready_out,
    output logic [$clog2(P_NUM_INPUTS)-1:0]      grant_out,
    output logic                                 active_out
);

    localparam int unsigned P_SEL_WIDTH = $clog2(P_NUM_INPUTS);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t                   state_q, state_d;
    logic [P_SEL_WIDTH-1:0]   grant_q, grant_d;
    logic [P_SEL_WIDTH-1:0]   ptr_q, ptr_d;
    logic [P_SEL_WIDTH-1:0]   ptr_inc;
    logic [P_SEL_WIDTH-1:0]   rr_pick;
    logic                     rr_found;
    logic [P_SEL_WIDTH-1:0]   out_sel;
    logic [P_DATA_WIDTH-1:0]  data_arr [P_NUM_INPUTS];

    for (genvar gi = 0; gi < P_NUM_INPUTS; gi++) begin : g_unpack
        assign data_arr[gi] = data_in[gi*P_DATA_WIDTH +: P_DATA_WIDTH];
    end

    // First requester at or after ptr, wrapping around.
    always_comb begin
        int unsigned idx;
        rr_found = 1'b0;
        rr_pick  = '0;
        for (int unsigned k = 0; k < P_NUM_INPUTS; k++) begin
            idx = 32'(ptr_q) + k;
            if (idx >= P_NUM_INPUTS) begin
                idx = idx - P_NUM_INPUTS;
            end
            if (!rr_found && valid_in[P_SEL_WIDTH'(idx)]) begin
                rr_found = 1'b1;
                rr_pick  = P_SEL_WIDTH'(idx);
            end
        end
    end

    assign ptr_inc = (grant_q == P_SEL_WIDTH'(P_NUM_INPUTS - 1)) ? '0
                                                                 : grant_q + P_SEL_WIDTH'(1);

    // Next-state and handshake logic; ready_in never depends on valid_in.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        ptr_d     = ptr_q;
        out_sel   = grant_q;
        valid_out = 1'b0;
        ready_in  = '0;
        case (state_q)
            ST_IDLE: begin
`ifdef RR_STREAM_ARBITER_FAST_PATH_EN
                out_sel     = '0;
                valid_out   = valid_in[0];
                ready_in[0] = ready_out;
                if (valid_in[0]) begin
                    grant_d = '0;
                    if (ready_out && last_in[0]) begin
                        ptr_d = P_SEL_WIDTH'(1);
                    end else begin
                        state_d = ST_ACTIVE;
                    end
                end else if (rr_found) begin
                    grant_d = rr_pick;
                    state_d = ST_ACTIVE;
                end
`else
                if (rr_found) begin
                    grant_d = rr_pick;
                    state_d = ST_ACTIVE;
                end
`endif
            end
            ST_ACTIVE: begin
                valid_out         = valid_in[grant_q];
                ready_in[grant_q] = ready_out;
                if (valid_in[grant_q] && ready_out && last_in[grant_q]) begin
                    state_d = ST_IDLE;
                    ptr_d   = ptr_inc;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (rst) begin
            valid_out = 1'b0;
            ready_in  = '0;
        end
    end

    assign data_out   = data_arr[out_sel];
    assign last_out   = last_in[out_sel];
    assign grant_out  = grant_q;
    assign active_out = (state_q == ST_ACTIVE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

endmodule

// File: doc/rr_stream_arbiter.md
# rr_stream_arbiter

N-input round-robin packet arbiter for valid/ready/last streams, merging P_NUM_INPUTS requesters onto one shared downstream stream. Once an input is granted it owns the output until its last beat is accepted; grants then rotate fairly. It sits in front of a shared egress datapath (DMA engine, MAC TX, shared FIFO) where more than two sources contend. The registered grant keeps ready outputs free of combinational paths from any valid input.

## Interface
- P_NUM_INPUTS, 4, number of requesters (2..16)
- P_DATA_WIDTH, 32, data width in bits
- P_SEL_WIDTH, $clog2(P_NUM_INPUTS), localparam, grant index width
- clk  input  1  clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- valid_in  input  P_NUM_INPUTS  per-input valid, bit i = input i
- last_in  input  P_NUM_INPUTS  per-input last
- data_in  input  P_NUM_INPUTS*P_DATA_WIDTH  per-input data, input i at bits [i*P_DATA_WIDTH +: P_DATA_WIDTH]
- ready_in  output  P_NUM_INPUTS  per-input ready
- valid_out  output  1  output valid
- last_out  output  1  output last
- data_out  output  P_DATA_WIDTH  output data
- ready_out  input  1  downstream ready
- grant_out  output  P_SEL_WIDTH  currently selected input index
- active_out  output  1  1 while a packet owns the output

## Operation
- State: IDLE, ACTIVE. Registers: state, grant[P_SEL_WIDTH], ptr[P_SEL_WIDTH] (next input with highest priority).
- IDLE: if any valid_in set, grant <= first i with valid_in[i] searching ptr, ptr+1, ... mod P_NUM_INPUTS; state <= ACTIVE. Else hold.
- ACTIVE: data_out/last_out = input grant; valid_out = valid_in[grant]; ready_in[grant] = ready_out; all other ready_in = 0.
- Beat accepted = valid_out && ready_out. On accepted beat with last_out: state <= IDLE, ptr <= grant+1 (wraps P_NUM_INPUTS-1 -> 0).
- Input valid may drop mid-packet; arbiter waits in ACTIVE (no timeout). Ungranted inputs are not disturbed; their valid holding high is legal.
- In IDLE (without fast path): valid_out = 0, ready_in = 0, data_out/last_out = input grant (don't-care).
- Reset: state IDLE, grant 0, ptr 0, active_out 0. While rst = 1: valid_out = 0, ready_in = 0 regardless of inputs. Reset mid-packet abandons the packet; no beat accepted in the reset cycle.
- ready_in is a function of state, grant and ready_out only; never of valid_in.

## Timing
- Grant latency: valid_in[i] first high at cycle T in IDLE -> grant_out = i, active_out = 1, first beat presented T+1.
- Packet end: last accepted at T -> IDLE at T+1; next packet's first beat T+2 earliest (one bubble cycle).
- Single-beat packet (valid+last): occupies exactly 2 cycles (arbitration + beat) when ready_out = 1.
- grant_out, active_out are registered; change only at clock edges.
- Simultaneous requests: exactly one granted per arbitration; losers served in ptr order on later arbitrations.

## Configuration
- RR_STREAM_ARBITER_FAST_PATH_EN defined: input 0 is the low-latency input. In IDLE, data/last_out select input 0, valid_out = valid_in[0], ready_in[0] = ready_out. If valid_in[0] in IDLE: grant <= 0 regardless of ptr; if that beat is accepted with last, stay IDLE and ptr <= 1; otherwise state <= ACTIVE (valid_out already asserted, grant is committed even if ready_out = 0). Inputs 1..N-1 arbitrated as above only when valid_in[0] = 0. Input 0 can starve others; documented trade-off.
- Undefined: all inputs identical, one-cycle grant latency, pure round robin.

## Test plan
- Reset: rst = 1 with valid_in = 4'b1111 -> valid_out = 0, ready_in = 0, grant_out = 0, active_out = 0.
- Single requester: input 2 sends 3 beats (0xA0, 0xA1, 0xA2 last), ready_out = 1 -> output beats on cycles T+1..T+3, grant_out = 2, active_out drops at T+4.
- Round robin: valid_in = 4'b1111 continuously, 1-beat packets -> grant order 0,1,2,3,0 with one bubble between each.
- Backpressure: ready_out toggles 1,0,0,1 mid-packet on input 1 -> no beat lost or duplicated, ready_in[1] mirrors ready_out, other ready_in = 0.
- Reset mid-packet: assert rst on beat 2 of 4 from input 3 -> next cycle IDLE, ptr = 0; subsequent request on input 1 granted normally.
- Fast path (macro defined): IDLE, valid_in[0] single beat last with ready_out = 1 -> accepted same cycle T, active_out stays 0; valid_in[0] and [2] together -> input 0 wins, input 2 granted after input 0's last.
